// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared Gray-code helpers and receiver state type
package gray_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        INIT,
        LOAD,
        TRACK
    } gray_rx_state_t;

    // Helpers take zero-extended operands so one definition serves every pointer width.
    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        for (int i = 0; i < MAX_W; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    function automatic logic popcount_gt1(input logic [MAX_W-1:0] x);
        return (x & (x - MAX_W'(1))) != '0;
    endfunction

endpackage

// File: rtl/gray_to_binary.sv
// rtl/gray_to_binary.sv - combinational Gray-to-binary decoder
module gray_to_binary #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/gray_ptr_receiver.sv
// rtl/gray_ptr_receiver.sv - synchronizes and decodes a Gray pointer from another clock domain
module gray_ptr_receiver
    import gray_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             clear_err,
    output logic [WIDTH-1:0] bin_out,
    output logic             bin_valid,
    output logic [WIDTH-1:0] delta,
    output logic             multi_bit_err,
    output logic [7:0]       err_count
);

    localparam int FILL_W = $clog2(SYNC_STAGES + 1);

    (* async_reg = "true" *) logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]  g_s;
    logic [WIDTH-1:0]  g_prev;
    logic [WIDTH-1:0]  g_dec;
    logic [FILL_W-1:0] fill_q;
    gray_rx_state_t    state_q, state_d;
    logic              load_en, upd_en, err_evt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], gray_in};
        end
    end

    assign g_s = sync_q[SYNC_STAGES-1];

    gray_to_binary #(.WIDTH(WIDTH)) u_dec (
        .gray (g_s),
        .bin  (g_dec)
    );

    // Fill counter keeps the FSM in INIT until reset-time zeros have left the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q <= '0;
        end else if (state_q == INIT) begin
            fill_q <= fill_q + FILL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    if (fill_q == FILL_W'(SYNC_STAGES - 1)) state_d = LOAD;
            LOAD:    state_d = TRACK;
            TRACK:   state_d = TRACK;
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        load_en = 1'b0;
        upd_en  = 1'b0;
        err_evt = 1'b0;
        case (state_q)
            LOAD: load_en = 1'b1;
            TRACK: begin
                upd_en  = (g_s != g_prev);
                err_evt = popcount_gt1(MAX_W'(g_s ^ g_prev));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_prev        <= '0;
            bin_out       <= '0;
            delta         <= '0;
            bin_valid     <= 1'b0;
            multi_bit_err <= 1'b0;
        end else begin
            bin_valid     <= load_en | upd_en;
            multi_bit_err <= err_evt;
            if (load_en) begin
                g_prev  <= g_s;
                bin_out <= g_dec;
                delta   <= '0;
            end else if (upd_en) begin
                g_prev  <= g_s;
                bin_out <= g_dec;
                delta   <= g_dec - bin_out;
            end
        end
    end

    // A clear that coincides with an error keeps that error counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= 8'd0;
        end else if (clear_err) begin
            err_count <= {7'd0, err_evt};
        end else if (err_evt && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_gray_ptr_receiver.sv
// tb/tb_gray_ptr_receiver.sv - scoreboard bench for gray_ptr_receiver
module tb_gray_ptr_receiver;

    typedef struct {
        logic [7:0] bin;
        logic [7:0] dlt;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] gray_in;
    logic       clear_err;
    logic [7:0] bin_out;
    logic       bin_valid;
    logic [7:0] delta;
    logic       multi_bit_err;
    logic [7:0] err_count;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    gray_ptr_receiver #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .gray_in       (gray_in),
        .clear_err     (clear_err),
        .bin_out       (bin_out),
        .bin_valid     (bin_valid),
        .delta         (delta),
        .multi_bit_err (multi_bit_err),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [7:0] g, input logic [7:0] eb, input logic [7:0] ed,
                        input logic ee, input logic [7:0] ec);
        exp_t e;
        e.bin = eb;
        e.dlt = ed;
        e.err = ee;
        e.cnt = ec;
        sb.push_back(e);
        gray_in = g;
        tick();
        tick();
    endtask

    task automatic expect_baseline(input logic [7:0] eb);
        exp_t e;
        e.bin = eb;
        e.dlt = 8'd0;
        e.err = 1'b0;
        e.cnt = 8'd0;
        sb.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bin_out"}, bin_out, 0);
        check({tag, "_bin_valid"}, bin_valid, 0);
        check({tag, "_delta"}, delta, 0);
        check({tag, "_multi_bit_err"}, multi_bit_err, 0);
        check({tag, "_err_count"}, err_count, 0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && bin_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", bin_valid, 0);
            end else begin
                e = sb.pop_front();
                check("bin_out", bin_out, e.bin);
                check("delta", delta, e.dlt);
                check("multi_bit_err", multi_bit_err, e.err);
                check("err_count", err_count, e.cnt);
            end
        end
        if (rst_n && multi_bit_err && !bin_valid) begin
            check("err_without_valid", multi_bit_err, 0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hold_cnt;
        int wait_cnt;
        rst_n     = 1'b0;
        gray_in   = 8'h3C;
        clear_err = 1'b0;
        repeat (3) tick();
        check_all_zero("in_reset");

        expect_baseline(8'h28);
        rst_n = 1'b1;
        tick();
        tick();
        check("load_not_early", bin_valid, 0);
        tick();
        check("load_pulse_edge3", bin_valid, 1);
        tick();

        rst_n   = 1'b0;
        gray_in = 8'h00;
        tick();
        expect_baseline(8'h00);
        rst_n = 1'b1;
        repeat (4) tick();

        for (int i = 1; i <= 256; i++) begin
            logic [7:0] b;
            b = 8'(i);
            step(b ^ (b >> 1), b, 8'd1, 1'b0, 8'd0);
        end

        for (int k = 1; k <= 300; k++) begin
            logic [7:0] c;
            c = (k > 255) ? 8'd255 : 8'(k);
            if (k % 2 == 1) step(8'h03, 8'd2, 8'd2, 1'b1, c);
            else            step(8'h00, 8'd0, 8'd254, 1'b1, c);
        end
        tick();
        tick();
        check("err_count_saturated", err_count, 255);

        begin
            exp_t e;
            e.bin = 8'd2;
            e.dlt = 8'd2;
            e.err = 1'b1;
            e.cnt = 8'd1;
            sb.push_back(e);
        end
        gray_in = 8'h03;
        tick();
        tick();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("clear_with_err_count", err_count, 1);
        check("clear_with_err_flag", multi_bit_err, 1);
        tick();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("clear_alone_count", err_count, 0);

        hold_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            hold_cnt += int'(bin_valid);
        end
        check("hold_valids", hold_cnt, 0);
        check("hold_bin_out", bin_out, 2);

        for (int i = 3; i <= 9; i++) begin
            logic [7:0] b;
            b = 8'(i);
            step(b ^ (b >> 1), b, 8'd1, 1'b0, 8'd0);
        end
        gray_in = 8'h0F;
        tick();
        #5;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        tick();
        expect_baseline(8'h0A);
        rst_n = 1'b1;
        tick();
        tick();
        check("restart_not_early", bin_valid, 0);
        tick();
        check("restart_load_pulse", bin_valid, 1);
        tick();

        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 20) begin
            tick();
            wait_cnt++;
        end
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
